// File: rtl/player_physics.sv
// Per-frame player integrator: horizontal wrap, gravity/bounce, upward scroll with
// height score, and fall-off-screen death. Every update happens on the frame tick.
module player_physics #(
    parameter int FPS         = 60,
    parameter int CLK         = 25_000_000,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int START_X     = 300,
    parameter int START_Y     = 400,
    parameter int SCROLL_LINE = 120,
    parameter int GRAVITY     = 1,
    parameter int MAX_FALL_V  = 15,
    parameter int JUMP_V      = -12
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [$clog2(CLK/FPS):0]    fps_counter,
    input  logic signed [8:0]           delta_x,
    input  logic [1:0]                  game_state,
    input  logic                        platform_hit,
    output logic [9:0]                  player_x,
    output logic signed [10:0]          player_y,
    output logic signed [7:0]           vy,
    output logic                        jump,
    output logic [7:0]                  scroll_dy,
    output logic [19:0]                 score,
    output logic                        game_over
);

    typedef enum logic [1:0] {IDLE, PLAY, DEAD} state_t;

    localparam logic signed [11:0] W_S      = 12'(SCREEN_W);
    localparam logic signed [11:0] H_S      = 12'(SCREEN_H);
    localparam logic signed [11:0] SCROLL_S = 12'(SCROLL_LINE);
    localparam logic signed [8:0]  GRAV_S   = 9'(GRAVITY);
    localparam logic signed [8:0]  MAXV_S   = 9'(MAX_FALL_V);
    localparam logic signed [8:0]  JUMP_S   = 9'(JUMP_V);

    state_t             state;
    logic               tick;
    logic               advance;
    logic               bounce;
    logic               scrolled;
    logic               dies;
    logic signed [11:0] xs;
    logic [9:0]         x_next;
    logic signed [8:0]  vy_sum;
    logic signed [8:0]  vy_next;
    logic signed [11:0] y_next;
    logic [7:0]         dy_next;
    logic [20:0]        score_sum;
    logic [19:0]        score_next;

    assign tick    = &fps_counter;
    assign advance = tick && ((state == PLAY) || (state == IDLE && game_state == 2'd1));

    // Next-frame kinematics, only committed when advance is high.
    always_comb begin
        xs = $signed({2'b00, player_x}) + $signed({{3{delta_x[8]}}, delta_x});
        if (xs < 0)
            x_next = 10'(xs + W_S);
        else if (xs >= W_S)
            x_next = 10'(xs - W_S);
        else
            x_next = 10'(xs);

        bounce = platform_hit && !vy[7];
        vy_sum = $signed({vy[7], vy}) + GRAV_S;
        if (bounce)
            vy_next = JUMP_S;
        else if (vy_sum > MAXV_S)
            vy_next = MAXV_S;
        else
            vy_next = vy_sum;

        y_next   = $signed({player_y[10], player_y}) + $signed({{3{vy_next[8]}}, vy_next});
        scrolled = y_next < SCROLL_S;
        dies     = y_next >= H_S;
        dy_next  = 8'(SCROLL_S - y_next);

        score_sum  = {1'b0, score} + {13'd0, dy_next};
        score_next = score_sum[20] ? '1 : score_sum[19:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            player_x  <= 10'(START_X);
            player_y  <= 11'(START_Y);
            vy        <= '0;
            jump      <= 1'b0;
            scroll_dy <= '0;
            score     <= '0;
            game_over <= 1'b0;
        end else begin
            jump <= 1'b0;
            if (advance) begin
                player_x <= x_next;
                vy       <= vy_next[7:0];
                jump     <= bounce;
                if (dies) begin
                    state     <= DEAD;
                    game_over <= 1'b1;
                    player_y  <= y_next[10:0];
                    scroll_dy <= '0;
                end else if (scrolled) begin
                    state     <= PLAY;
                    player_y  <= SCROLL_S[10:0];
                    scroll_dy <= dy_next;
                    score     <= score_next;
                end else begin
                    state     <= PLAY;
                    player_y  <= y_next[10:0];
                    scroll_dy <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_player_physics.sv
// Randomized bench for player_physics against an integer-arithmetic game model.
module tb_player_physics;

    localparam int FW = $clog2(25_000_000 / 60) + 1;

    logic                 clk;
    logic                 rst;
    logic [FW-1:0]        fps_counter;
    logic signed [8:0]    delta_x;
    logic [1:0]           game_state;
    logic                 platform_hit;
    logic [9:0]           player_x;
    logic signed [10:0]   player_y;
    logic signed [7:0]    vy;
    logic                 jump;
    logic [7:0]           scroll_dy;
    logic [19:0]          score;
    logic                 game_over;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: 0 = idle, 1 = play, 2 = dead
    int m_state, m_x, m_y, m_vy, m_jump, m_dy, m_score, m_over;

    player_physics dut (
        .clk          (clk),
        .rst          (rst),
        .fps_counter  (fps_counter),
        .delta_x      (delta_x),
        .game_state   (game_state),
        .platform_hit (platform_hit),
        .player_x     (player_x),
        .player_y     (player_y),
        .vy           (vy),
        .jump         (jump),
        .scroll_dy    (scroll_dy),
        .score        (score),
        .game_over    (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelStep(input bit tk, input int dx, input int gs, input bit hit, input bit rs);
        int xs, yn;
        bit bounced;
        bounced = 0;
        if (rs) begin
            m_state = 0; m_x = 300; m_y = 400; m_vy = 0;
            m_jump = 0; m_dy = 0; m_score = 0; m_over = 0;
            return;
        end
        if (tk && m_state != 2 && (m_state == 1 || gs == 1)) begin
            m_state = 1;
            xs = m_x + dx;
            if (xs < 0) xs += 640;
            else if (xs >= 640) xs -= 640;
            m_x = xs;
            if (hit && m_vy >= 0) begin
                m_vy = -12;
                bounced = 1;
            end else begin
                m_vy = (m_vy + 1 > 15) ? 15 : m_vy + 1;
            end
            yn = m_y + m_vy;
            if (yn >= 480) begin
                m_state = 2; m_over = 1; m_y = yn; m_dy = 0;
            end else if (yn < 120) begin
                m_y = 120;
                m_dy = 120 - yn;
                m_score = (m_score + m_dy > 20'hFFFFF) ? 20'hFFFFF : m_score + m_dy;
            end else begin
                m_y = yn; m_dy = 0;
            end
        end
        m_jump = bounced;
    endtask

    task automatic checkAll();
        checkOutput("player_x",  int'(player_x),  m_x);
        checkOutput("player_y",  int'(player_y),  m_y);
        checkOutput("vy",        int'(vy),        m_vy);
        checkOutput("jump",      int'(jump),      m_jump);
        checkOutput("scroll_dy", int'(scroll_dy), m_dy);
        checkOutput("score",     int'(score),     m_score);
        checkOutput("game_over", int'(game_over), m_over);
    endtask

    // One clock: drive inputs, advance the model on the edge, check 1 time unit later.
    task automatic applyStimulus(input bit tk, input int dx, input int gs, input bit hit, input bit rs);
        if (tk) begin
            fps_counter = '1;
        end else begin
            fps_counter = FW'($urandom);
            if (&fps_counter) fps_counter[$urandom_range(0, FW-1)] = 1'b0;
        end
        delta_x      = 9'(dx);
        game_state   = 2'(gs);
        platform_hit = hit;
        rst          = rs;
        @(posedge clk);
        modelStep(tk, dx, gs, hit, rs);
        #1;
        checkAll();
    endtask

    initial begin
        int y_exp[3];
        int hp, dx, gs, ticks;
        bit tk, hit, rs;
        y_exp[0] = 401; y_exp[1] = 403; y_exp[2] = 406;

        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("reset_x", int'(player_x), 300);
        checkOutput("reset_y", int'(player_y), 400);

        for (int i = 0; i < 3; i++) applyStimulus(1, 5, 0, 0, 0);
        checkOutput("idle_x", int'(player_x), 300);
        checkOutput("idle_vy", int'(vy), 0);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 5, 1, 0, 0);
            checkOutput("play_vy", int'(vy), i + 1);
            checkOutput("play_y", int'(player_y), y_exp[i]);
            applyStimulus(0, 5, 1, 0, 0);
        end
        checkOutput("play_x", int'(player_x), 315);

        ticks = 0;
        while (!game_over && ticks < 40) begin
            applyStimulus(1, -7, 0, 0, 0);
            ticks++;
        end
        checkOutput("death_reached", int'(game_over), 1);
        for (int i = 0; i < 3; i++) applyStimulus(1, 9, 1, 1, 0);
        applyStimulus(1, 5, 1, 1, 1);
        checkOutput("rst_on_tick_x", int'(player_x), 300);
        checkOutput("rst_on_tick_over", int'(game_over), 0);

        for (int g = 0; g < 30; g++) begin
            applyStimulus(0, 0, 0, 0, 1);
            hp = $urandom_range(0, 3);
            for (int c = 0; c < 300; c++) begin
                tk  = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 3) == 0)
                    dx = int'($urandom_range(0, 10)) - 5;
                else
                    dx = int'($urandom_range(0, 511)) - 256;
                gs  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : 1;
                hit = ($urandom_range(0, 3) < hp);
                rs  = ($urandom_range(0, 299) == 0);
                applyStimulus(tk, dx, gs, hit, rs);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
